// File: rtl/rf_param_bypass.sv
// Parametrised multi-port register file with write-to-read bypass and bulk-clear engine.
// Latency: reads combinational (bypass same cycle); writes land on the next rising clk; clear takes DEPTH cycles.
// Backpressure: busy high during a clear; writes are dropped (and flagged in err) while busy.
module rf_param_bypass #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int SEL_W   = 3,
  parameter int NRD     = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*SEL_W-1:0] rd_sel,
  output logic [NRD*WIDTH-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [SEL_W-1:0]     wr_sel,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 clr_req,
  output logic                 busy,
  output logic                 err,
  input  logic                 err_clr
);

  // One extra bit so DEPTH == 2**SEL_W is representable in range compares.
  localparam logic [SEL_W:0]   DEPTH_C = (SEL_W+1)'(DEPTH);
  localparam logic [SEL_W-1:0] LAST    = SEL_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [SEL_W-1:0] rsel [NRD];
  logic             wr_ok;
  logic             wr_bad;
  logic             rd_bad;
  logic             err_set;

  // Unpack the read selects once so the read mux stays readable.
  for (genvar g = 0; g < NRD; g++) begin : g_sel
    assign rsel[g] = rd_sel[g*SEL_W +: SEL_W];
  end

  assign busy    = (state_q == CLEAR);
  assign wr_bad  = wr_en && ({1'b0, wr_sel} >= DEPTH_C);
  // A write only counts when it will really land in the array; bypass reuses this.
  assign wr_ok   = wr_en && !busy && !wr_bad && !((ZERO_R0 != 0) && (wr_sel == '0));
  assign err_set = wr_bad || rd_bad || (wr_en && busy);

  // Read mux per port: out-of-range and hardwired r0 give 0, then bypass, then array.
  always_comb begin
    rd_data = '0;
    rd_bad  = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      if ({1'b0, rsel[k]} >= DEPTH_C) begin
        rd_bad = 1'b1;
      end else if ((ZERO_R0 != 0) && (rsel[k] == '0)) begin
        rd_data[k*WIDTH +: WIDTH] = '0;
      end else if ((BYPASS != 0) && wr_ok && (rsel[k] == wr_sel)) begin
        rd_data[k*WIDTH +: WIDTH] = wr_data;
      end else begin
        rd_data[k*WIDTH +: WIDTH] = mem[rsel[k]];
      end
    end
  end

  // Clear FSM next-state: walk ptr 0..DEPTH-1 once per request, ignore requests while walking.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        if (ptr_q == LAST) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + SEL_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Clear FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Register array: clear walk zeroes one entry per cycle; normal writes are blocked while busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state_q == CLEAR) begin
      mem[ptr_q] <= '0;
    end else if (wr_ok) begin
      mem[wr_sel] <= wr_data;
    end
  end

  // Sticky error flag: a new error in the same cycle as err_clr keeps it set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_param_bypass.sv
// Directed bench for rf_param_bypass: three instances (default, hardwired r0, DEPTH=6) on shared inputs.
// Inputs driven 1ns after the rising edge, outputs sampled 1ns later.
// Summary line reports comparison and error counts.
module tb_rf_param_bypass;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  rd_sel;
  logic        wr_en;
  logic [2:0]  wr_sel;
  logic [15:0] wr_data;
  logic        clr_req;
  logic        err_clr;

  logic [31:0] rd_data_a, rd_data_z, rd_data_d;
  logic        busy_a, busy_z, busy_d;
  logic        err_a, err_z, err_d;

  int n_chk = 0;
  int n_err = 0;
  int busy_cnt;

  always #5 clk = ~clk;

  rf_param_bypass #(.WIDTH(16), .DEPTH(8), .SEL_W(3), .NRD(2), .BYPASS(1), .ZERO_R0(0)) u_a (
    .clk(clk), .rst(rst), .rd_sel(rd_sel), .rd_data(rd_data_a), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_data(wr_data), .clr_req(clr_req), .busy(busy_a), .err(err_a), .err_clr(err_clr));

  rf_param_bypass #(.WIDTH(16), .DEPTH(8), .SEL_W(3), .NRD(2), .BYPASS(1), .ZERO_R0(1)) u_z (
    .clk(clk), .rst(rst), .rd_sel(rd_sel), .rd_data(rd_data_z), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_data(wr_data), .clr_req(clr_req), .busy(busy_z), .err(err_z), .err_clr(err_clr));

  rf_param_bypass #(.WIDTH(16), .DEPTH(6), .SEL_W(3), .NRD(2), .BYPASS(1), .ZERO_R0(0)) u_d (
    .clk(clk), .rst(rst), .rd_sel(rd_sel), .rd_data(rd_data_d), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_data(wr_data), .clr_req(clr_req), .busy(busy_d), .err(err_d), .err_clr(err_clr));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; rd_sel = '0; wr_en = 1'b0; wr_sel = '0; wr_data = '0;
    clr_req = 1'b0; err_clr = 1'b0;
    step;
    #1;
    chk("rst_rd", rd_data_a, 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    chk("rst_err", 32'(err_a), 32'h0);
    step;
    rst = 1'b1;

    // Every register on both ports reads zero after reset.
    for (int s = 0; s < 8; s++) begin
      step;
      rd_sel = {3'(s), 3'(s)};
      #1;
      chk("rst_all", rd_data_a, 32'h0);
    end
    chk("post_rst_busy", 32'(busy_a), 32'h0);

    // Bypass on write to r5; port1 on r4 stays zero.
    step;
    wr_en = 1'b1; wr_sel = 3'd5; wr_data = 16'hBEEF; rd_sel = {3'd4, 3'd5};
    #1;
    chk("byp_p0", 32'(rd_data_a[15:0]), 32'hBEEF);
    chk("byp_p1", 32'(rd_data_a[31:16]), 32'h0);
    step;
    wr_en = 1'b0;
    #1;
    chk("stored_p0", 32'(rd_data_a[15:0]), 32'hBEEF);
    chk("stored_p1", 32'(rd_data_a[31:16]), 32'h0);

    // Hardwired r0: write is ignored and never bypassed.
    step;
    wr_en = 1'b1; wr_sel = 3'd0; wr_data = 16'h1234; rd_sel = {3'd0, 3'd0};
    #1;
    chk("z_r0_nobyp", 32'(rd_data_z[15:0]), 32'h0);
    chk("a_r0_byp", 32'(rd_data_a[15:0]), 32'h1234);
    step;
    wr_sel = 3'd1; rd_sel = {3'd1, 3'd0};
    #1;
    chk("z_r1_byp", 32'(rd_data_z[31:16]), 32'h1234);
    step;
    wr_en = 1'b0;
    #1;
    chk("z_r0_read", 32'(rd_data_z[15:0]), 32'h0);
    chk("z_r1_read", 32'(rd_data_z[31:16]), 32'h1234);
    chk("a_r0_read", 32'(rd_data_a[15:0]), 32'h1234);

    // DEPTH=6 instance: range errors on read/write selects.
    rd_sel = '0; err_clr = 1'b1;
    step;
    err_clr = 1'b0;
    #1;
    chk("d_err_cleared", 32'(err_d), 32'h0);
    wr_en = 1'b1; wr_sel = 3'd7; wr_data = 16'hFFFF;
    step;
    wr_en = 1'b0; rd_sel = {3'd5, 3'd6};
    #1;
    chk("d_err_wr7", 32'(err_d), 32'h1);
    chk("d_rd6", 32'(rd_data_d[15:0]), 32'h0);
    chk("d_r5_kept", 32'(rd_data_d[31:16]), 32'hBEEF);
    step;
    rd_sel = '0; err_clr = 1'b1;
    step;
    err_clr = 1'b0;
    #1;
    chk("d_errclr", 32'(err_d), 32'h0);
    err_clr = 1'b1; rd_sel = {3'd0, 3'd7};
    step;
    rd_sel = '0;
    #1;
    chk("d_set_wins", 32'(err_d), 32'h1);
    step;
    err_clr = 1'b0;
    #1;
    chk("d_errclr2", 32'(err_d), 32'h0);
    chk("a_err_clean", 32'(err_a), 32'h0);

    // Load r0..r7 with 0x0101*i, then bulk clear.
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_sel = 3'(i); wr_data = 16'(16'h0101 * i);
      step;
    end
    wr_en = 1'b0; clr_req = 1'b1; rd_sel = {3'd7, 3'd0};
    #1;
    chk("clr_busy_pre", 32'(busy_a), 32'h0);
    step;
    busy_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      wr_en = 1'b0; clr_req = 1'b0; rd_sel = {3'd7, 3'd0};
      if (c == 3) rd_sel = {3'd7, 3'd2};
      if (c == 4) begin
        wr_en = 1'b1; wr_sel = 3'd3; wr_data = 16'hAAAA; rd_sel = {3'd3, 3'd3}; clr_req = 1'b1;
      end
      #1;
      if (busy_a) busy_cnt++;
      if (c == 3) begin
        chk("mid_r7_old", 32'(rd_data_a[31:16]), 32'h0707);
        chk("mid_r2_zero", 32'(rd_data_a[15:0]), 32'h0);
      end
      if (c == 4) chk("busy_nobyp", 32'(rd_data_a[15:0]), 32'h0);
      if (c == 5) chk("busy_wr_err", 32'(err_a), 32'h1);
      if (c == 8) chk("busy_done", 32'(busy_a), 32'h0);
      step;
    end
    wr_en = 1'b0; clr_req = 1'b0;
    chk("busy_cycles", 32'(busy_cnt), 32'd8);
    for (int s = 0; s < 8; s++) begin
      rd_sel = {3'(s), 3'(s)};
      #1;
      chk("post_clr", rd_data_a, 32'h0);
      step;
    end

    // Reset in the middle of a clear.
    wr_en = 1'b1; wr_sel = 3'd6; wr_data = 16'h6666;
    step;
    wr_sel = 3'd7; wr_data = 16'h7777;
    step;
    wr_en = 1'b0; clr_req = 1'b1;
    step;
    clr_req = 1'b0;
    step;
    step;
    step;
    rst = 1'b0; rd_sel = {3'd7, 3'd6};
    #1;
    chk("rstmid_busy", 32'(busy_a), 32'h0);
    chk("rstmid_regs", rd_data_a, 32'h0);
    step;
    rst = 1'b1;
    step;
    rd_sel = {3'd7, 3'd6};
    #1;
    chk("rstmid_after", rd_data_a, 32'h0);
    clr_req = 1'b1;
    step;
    clr_req = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (busy_a) busy_cnt++;
      step;
    end
    chk("reclr_cycles", 32'(busy_cnt), 32'd8);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
